wts_timer_bank: RTL and testbench
=================================

// Module: wts_timer_bank
// PURPOSE
//  Multi-channel successor to the two-channel wave-timer interrupt block; NUM_CH channels, each with its own trigger divider.
//  Each channel counts wave-address triggers and fires after reg_period+1 triggers.
//  On fire it latches the wave address and asserts a per-channel pending flag.
//  Sits between the wave-table address generators and the CPU register file.
//  Drives one shared active-low interrupt plus a lowest-pending-channel vector.
// PARAMETERS
//  NUM_CH  4  number of timer channels (1..16)
//  ADDR_W  7  width of captured wave address
//  CNT_W   8  width of per-channel trigger divider
// PORTS
//  clk          in   1                 system clock, all state on rising edge
//  nreset       in   1                 asynchronous reset, active-low
//  ch_trigger   in   NUM_CH            per-channel trigger strobe, 1 clk wide
//  ch_address   in   NUM_CH*ADDR_W     per-channel wave address, ch i at [i*ADDR_W +: ADDR_W]
//  reg_enable   in   NUM_CH            per-channel enable (level)
//  reg_clear    in   NUM_CH            per-channel clear strobe, 1 clk wide
//  reg_period   in   NUM_CH*CNT_W      per-channel divider, fire after period+1 triggers
//  ch_status    out  NUM_CH*(ADDR_W+1) per-channel {npend, address}, ch i at [i*(ADDR_W+1) +: ADDR_W+1]
//  ch_overrun   out  NUM_CH            fire occurred while already pending (see CONFIGURATION)
//  int_vector   out  $clog2(NUM_CH)    index of lowest-numbered pending channel
//  nint         out  1                 interrupt, active-low = AND of all npend
// BEHAVIOUR
//  - Clock and reset: clk rising edge; reset is nreset, asynchronous, active-low.
//  - Reset values: npend=1, address=0, trig_cnt=0, overrun=0. Outputs: nint=1, int_vector=0, ch_overrun=0.
//  - Per-channel priority each cycle: reg_clear > (reg_enable & ch_trigger) > hold.
//  - reg_clear: npend<=1, address<=0, trig_cnt<=0, overrun<=0. A trigger in the same cycle is dropped.
//  - Trigger with enable, trig_cnt >= period: trig_cnt<=0; fire.
//    The >= compare means lowering the period mid-count never wraps.
//  - Trigger with enable, trig_cnt < period: trig_cnt<=trig_cnt+1; no fire.
//  - Fire with npend=1: npend<=0; address<=ch_address of that channel, sampled in the same cycle.
//  - Fire with npend=0: address and npend hold, so the first-captured address is kept.
//    Overrun handling per CONFIGURATION.
//  - reg_enable=0: triggers are ignored; trig_cnt, npend and address hold.
//    Disabling never clears a pending flag.
//  - period=0: every enabled trigger fires.
//  - Latency: a trigger sampled at edge N gives npend, nint and int_vector valid after edge N.
//    No extra pipeline stage; the outputs are combinational decode of flops only.
//  - Channels are fully independent; simultaneous triggers/clears on different channels all take effect.
//  - int_vector: lowest index i with npend[i]=0; equals 0 when nothing is pending (qualify with nint).
//  - A reset assertion mid-count returns all state to reset values immediately.
// CONFIGURATION
//  WTS_TIMER_OVERRUN_EN defined:
//   - A fire with npend=0 sets overrun<=1 (sticky until reg_clear or reset).
//   - ch_overrun[i] reflects the per-channel overrun flag.
//   - If a fire and reg_clear occur in the same cycle, the clear wins and overrun stays 0.
//  WTS_TIMER_OVERRUN_EN undefined:
//   - No overrun flop is built; ch_overrun is tied to 0.
//   - A fire while pending is silently absorbed.
// TESTING
//  1 Reset: assert nreset=0 mid-activity -> all npend=1, addresses 0, nint=1, int_vector=0, ch_overrun=0.
//  2 Divider: ch1 period=2, enable=1, 3 triggers with addresses 0x10,0x11,0x12
//    -> no fire after triggers 1,2; after trigger 3 ch1 status={0,0x12}, nint=0, int_vector=1.
//  3 Priority: ch2 and ch0 fire in the same cycle -> int_vector=0;
//    clear ch0 -> int_vector=2, nint=0; clear ch2 -> nint=1.
//  4 Clear vs trigger: ch3 period=0, reg_clear and ch_trigger in the same cycle
//    -> ch3 stays npend=1, trig_cnt=0; the next lone trigger fires.
//  5 Overrun (macro on): ch0 period=0, trigger addr 0x05 then addr 0x06
//    -> status={0,0x05}, ch_overrun[0]=1; reg_clear -> ch_overrun[0]=0.
//    Macro off: same stimulus -> ch_overrun=0, status={0,0x05}.
//  6 Period shrink: ch1 period=5, 4 triggers, then period=1, 1 trigger
//    -> fires on that trigger (4>=1), trig_cnt=0.

Source files
------------

// File: rtl/wts_timer_bank.sv
// Bank of NUM_CH wave-address trigger dividers with per-channel pending/address capture,
// a shared active-low interrupt and a lowest-pending-channel vector.
// Optional sticky overrun tracking is built when WTS_TIMER_OVERRUN_EN is defined.
module wts_timer_bank #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned CNT_W  = 8,
    localparam int unsigned VEC_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned ST_W  = ADDR_W + 1
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic [NUM_CH-1:0]        ch_trigger,
    input  logic [NUM_CH*ADDR_W-1:0] ch_address,
    input  logic [NUM_CH-1:0]        reg_enable,
    input  logic [NUM_CH-1:0]        reg_clear,
    input  logic [NUM_CH*CNT_W-1:0]  reg_period,
    output logic [NUM_CH*ST_W-1:0]   ch_status,
    output logic [NUM_CH-1:0]        ch_overrun,
    output logic [VEC_W-1:0]         int_vector,
    output logic                     nint
);

    logic [NUM_CH-1:0]             npend_q, npend_d;
    logic [NUM_CH-1:0][ADDR_W-1:0] addr_q,  addr_d;
    logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q,   cnt_d;
`ifdef WTS_TIMER_OVERRUN_EN
    logic [NUM_CH-1:0]             ovr_q,   ovr_d;
`endif

    // Per-channel next state: clear beats an enabled trigger, otherwise hold.
    always_comb begin
        npend_d = npend_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
`ifdef WTS_TIMER_OVERRUN_EN
        ovr_d   = ovr_q;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (reg_clear[i]) begin
                npend_d[i] = 1'b1;
                addr_d[i]  = '0;
                cnt_d[i]   = '0;
`ifdef WTS_TIMER_OVERRUN_EN
                ovr_d[i]   = 1'b0;
`endif
            end else if (reg_enable[i] && ch_trigger[i]) begin
                // >= so a period lowered below the running count fires instead of wrapping
                if (cnt_q[i] >= reg_period[i*CNT_W +: CNT_W]) begin
                    cnt_d[i] = '0;
                    if (npend_q[i]) begin
                        npend_d[i] = 1'b0;
                        addr_d[i]  = ch_address[i*ADDR_W +: ADDR_W];
                    end else begin
`ifdef WTS_TIMER_OVERRUN_EN
                        ovr_d[i] = 1'b1;
`endif
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            npend_q <= '1;
            addr_q  <= '0;
            cnt_q   <= '0;
`ifdef WTS_TIMER_OVERRUN_EN
            ovr_q   <= '0;
`endif
        end else begin
            npend_q <= npend_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
`ifdef WTS_TIMER_OVERRUN_EN
            ovr_q   <= ovr_d;
`endif
        end
    end

`ifdef WTS_TIMER_OVERRUN_EN
    assign ch_overrun = ovr_q;
`else
    assign ch_overrun = '0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_status
        assign ch_status[g*ST_W +: ST_W] = {npend_q[g], addr_q[g]};
    end

    assign nint = &npend_q;

    // Lowest-numbered pending channel; 0 when idle, qualified by nint.
    always_comb begin
        logic found;
        found      = 1'b0;
        int_vector = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!npend_q[i] && !found) begin
                int_vector = VEC_W'(i);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wts_timer_bank.sv
// Directed scoreboard bench for wts_timer_bank (NUM_CH=4, ADDR_W=7, CNT_W=8).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_wts_timer_bank;

`ifdef WTS_TIMER_OVERRUN_EN
    localparam bit OVR_ON = 1'b1;
`else
    localparam bit OVR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nreset;
    logic [3:0]  trig, clr, en;
    logic [27:0] addr;
    logic [31:0] period;
    logic [31:0] ch_status;
    logic [3:0]  ch_overrun;
    logic [1:0]  int_vector;
    logic        nint;

    typedef struct packed {
        logic [31:0] status;
        logic [3:0]  ovr;
        logic [1:0]  vec;
        logic        nint;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    tests  = 0;
    int    failed = 0;

    wts_timer_bank dut (
        .clk        (clk),
        .nreset     (nreset),
        .ch_trigger (trig),
        .ch_address (addr),
        .reg_enable (en),
        .reg_clear  (clr),
        .reg_period (period),
        .ch_status  (ch_status),
        .ch_overrun (ch_overrun),
        .int_vector (int_vector),
        .nint       (nint)
    );

    always #5 clk = ~clk;

    task automatic expect_st(input string nm, input logic [3:0] np,
                             input logic [6:0] a0, input logic [6:0] a1,
                             input logic [6:0] a2, input logic [6:0] a3,
                             input logic [3:0] ov, input logic [1:0] v, input logic ni);
        exp_t e;
        e.status = {np[3], a3, np[2], a2, np[1], a1, np[0], a0};
        e.ovr    = ov;
        e.vec    = v;
        e.nint   = ni;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic expect_idle(input string nm);
        expect_st(nm, 4'hF, 7'h0, 7'h0, 7'h0, 7'h0, 4'h0, 2'd0, 1'b1);
    endtask

    // One clock with the current inputs; strobes drop right after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        trig = '0;
        clr  = '0;
    endtask

    task automatic set_addr(input int ch, input logic [6:0] a);
        addr[ch*7 +: 7] = a;
    endtask

    task automatic set_period(input int ch, input logic [7:0] p);
        period[ch*8 +: 8] = p;
    endtask

    // Monitor: compares DUT outputs at the falling edge whenever an expectation is queued.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            tests++;
            if (ch_status !== e.status) begin
                failed++;
                $display("FAIL %s status: got %h want %h", nm, ch_status, e.status);
            end
            tests++;
            if (ch_overrun !== e.ovr) begin
                failed++;
                $display("FAIL %s overrun: got %b want %b", nm, ch_overrun, e.ovr);
            end
            tests++;
            if (int_vector !== e.vec) begin
                failed++;
                $display("FAIL %s int_vector: got %0d want %0d", nm, int_vector, e.vec);
            end
            tests++;
            if (nint !== e.nint) begin
                failed++;
                $display("FAIL %s nint: got %b want %b", nm, nint, e.nint);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset = 1'b0;
        trig = '0; clr = '0; en = '0; addr = '0; period = '0;
        repeat (2) @(posedge clk);
        #1;
        expect_idle("reset_init");
        @(posedge clk);
        #1;
        nreset = 1'b1;

        // Divider: fire on the third trigger with period 2
        set_period(1, 8'd2); en = 4'b0010;
        set_addr(1, 7'h10); trig = 4'b0010; step(); expect_idle("div_t1");
        set_addr(1, 7'h11); trig = 4'b0010; step(); expect_idle("div_t2");
        set_addr(1, 7'h12); trig = 4'b0010; step();
        expect_st("div_t3", 4'b1101, 7'h0, 7'h12, 7'h0, 7'h0, 4'h0, 2'd1, 1'b0);
        clr = 4'b0010; step(); expect_idle("div_clr");

        // Priority between simultaneous fires
        set_period(0, 8'd0); set_period(2, 8'd0); en = 4'b0111;
        set_addr(0, 7'h20); set_addr(2, 7'h22); trig = 4'b0101; step();
        expect_st("prio_both", 4'b1010, 7'h20, 7'h0, 7'h22, 7'h0, 4'h0, 2'd0, 1'b0);
        clr = 4'b0001; step();
        expect_st("prio_clr0", 4'b1011, 7'h0, 7'h0, 7'h22, 7'h0, 4'h0, 2'd2, 1'b0);
        clr = 4'b0100; step(); expect_idle("prio_clr2");

        // Clear beats a same-cycle trigger
        set_period(3, 8'd0); en = 4'b1111;
        set_addr(3, 7'h33); clr = 4'b1000; trig = 4'b1000; step(); expect_idle("clr_vs_trig");
        set_addr(3, 7'h34); trig = 4'b1000; step();
        expect_st("lone_trig", 4'b0111, 7'h0, 7'h0, 7'h0, 7'h34, 4'h0, 2'd3, 1'b0);
        clr = 4'b1000; step(); expect_idle("ch3_clr");

        // Enable gating; disabling keeps a pending flag
        en = 4'b0000; set_addr(0, 7'h2A); trig = 4'b0001; step(); expect_idle("disabled");
        en = 4'b0001; set_addr(0, 7'h2B); trig = 4'b0001; step();
        expect_st("en_fire", 4'b1110, 7'h2B, 7'h0, 7'h0, 7'h0, 4'h0, 2'd0, 1'b0);
        en = 4'b0000; step();
        expect_st("dis_hold", 4'b1110, 7'h2B, 7'h0, 7'h0, 7'h0, 4'h0, 2'd0, 1'b0);
        clr = 4'b0001; step(); expect_idle("dis_clr");

        // Overrun: second fire keeps first address
        en = 4'b0001;
        set_addr(0, 7'h05); trig = 4'b0001; step();
        expect_st("ovr_first", 4'b1110, 7'h05, 7'h0, 7'h0, 7'h0, 4'h0, 2'd0, 1'b0);
        set_addr(0, 7'h06); trig = 4'b0001; step();
        expect_st("ovr_second", 4'b1110, 7'h05, 7'h0, 7'h0, 7'h0, {3'b000, OVR_ON}, 2'd0, 1'b0);
        clr = 4'b0001; step(); expect_idle("ovr_clr");
        set_addr(0, 7'h07); trig = 4'b0001; step();
        expect_st("ovr_pend", 4'b1110, 7'h07, 7'h0, 7'h0, 7'h0, 4'h0, 2'd0, 1'b0);
        clr = 4'b0001; trig = 4'b0001; step(); expect_idle("ovr_clr_wins");

        // Period shrink below running count fires without wrap
        set_period(1, 8'd5); en = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            set_addr(1, 7'(7'h30 + k)); trig = 4'b0010; step();
        end
        expect_idle("shrink_pre");
        set_period(1, 8'd1); set_addr(1, 7'h3A); trig = 4'b0010; step();
        expect_st("shrink_fire", 4'b1101, 7'h0, 7'h3A, 7'h0, 7'h0, 4'h0, 2'd1, 1'b0);
        set_addr(1, 7'h3B); trig = 4'b0010; step();
        expect_st("shrink_cnt0", 4'b1101, 7'h0, 7'h3A, 7'h0, 7'h0, 4'h0, 2'd1, 1'b0);
        trig = 4'b0010; step();
        expect_st("shrink_refire", 4'b1101, 7'h0, 7'h3A, 7'h0, 7'h0, {2'b00, OVR_ON, 1'b0}, 2'd1, 1'b0);
        clr = 4'b0010; step(); expect_idle("shrink_clr");

        // Asynchronous reset mid-count
        set_period(2, 8'd3); set_period(0, 8'd0); en = 4'b0101;
        trig = 4'b0100; step();
        trig = 4'b0100; step();
        set_addr(0, 7'h11); trig = 4'b0001; step();
        expect_st("pre_reset", 4'b1110, 7'h11, 7'h0, 7'h0, 7'h0, 4'h0, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        nreset = 1'b0;
        expect_idle("reset_mid");
        @(posedge clk);
        #1;
        nreset = 1'b1;
        trig = 4'b0100; step();
        trig = 4'b0100; step(); expect_idle("cnt_reset");
        trig = 4'b0100; step();
        set_addr(2, 7'h44); trig = 4'b0100; step();
        expect_st("post_reset_fire", 4'b1011, 7'h0, 7'h0, 7'h44, 7'h0, 4'h0, 2'd2, 1'b0);

        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
